parity_error_checker: RTL and testbench
=======================================

PARITY_ERROR_CHECKER -- requirements
Module: parity_error_checker

Interface
REQ-001 Parameter DATA_W, default 6, width of the checked data word.
REQ-002 Parameter PARITY_ODD, default 0; 0 = even parity expected, 1 = odd parity expected.
REQ-003 Parameter CNT_W, default 8, width of the error counter.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port data, input, DATA_W bits: word under check, including its parity bit.
REQ-008 Port data_valid, input, 1 bit: when 1, data is sampled and checked this cycle.
REQ-009 Port clear, input, 1 bit: synchronous clear of error_sticky and error_count.
REQ-010 Port error, output, 1 bit: parity result of the most recently checked word.
REQ-011 Port error_sticky, output, 1 bit: set once any checked word fails; held until clear.
REQ-012 Port error_count, output, CNT_W bits: count of failed words, saturating.

Function
REQ-013 Parity SHALL be the XOR reduction of all DATA_W bits of data.
- Even mode (PARITY_ODD=0): word fails when the XOR is 1, i.e. an odd number of ones.
- Odd mode (PARITY_ODD=1): word fails when the XOR is 0.
REQ-014 error SHALL be registered, with 1-cycle latency.
- Edge where data_valid=1: error takes the fail result of that word.
- Edge where data_valid=0: error holds its value.
REQ-015 error_sticky SHALL set on any edge that checks a failing word.
- On an edge with clear=1 and no failing check: it returns to 0.
- Failing check and clear on the same edge: set wins, so error_sticky=1.
REQ-016 error_count SHALL increment by 1 on each edge that checks a failing word, and SHALL saturate at all-ones (255 by default) without wrapping.
REQ-017 Edge with clear=1 and no failing check: error_count SHALL become 0.
REQ-018 Failing check and clear on the same edge: error_count SHALL become 1.
REQ-019 clear SHALL NOT affect error.
REQ-020 data and control inputs SHALL be treated as synchronous to clk; the block contains no combinational path from inputs to outputs.
REQ-021 Passing words and idle cycles (data_valid=0) SHALL leave error_sticky and error_count unchanged.

Reset
REQ-022 While rst_n=0, outputs SHALL be forced immediately, independent of clk: error=0, error_sticky=0, error_count=0.
REQ-023 Reset asserted mid-operation SHALL discard all state, including a saturated counter.
REQ-024 After rst_n deasserts, the first edge with data_valid=1 SHALL be checked normally.

Verification
REQ-025 Even mode, data=6'b000000 with valid -> error=0 one cycle later; sticky=0; count=0.
REQ-026 Even mode, words checked in sequence -> responses:
- 6'b000100 -> error=1.
- then 6'b100100 -> error=0.
- then 6'b101000 -> error=0.
- afterwards sticky=1, count=1.
REQ-027 Odd mode (PARITY_ODD=1), data=6'b000100 -> error=0; data=6'b100100 -> error=1.
REQ-028 Even mode, 300 consecutive valid 6'b000001 words -> count stops at 255; sticky=1; error=1.
- Then clear=1 for one cycle -> count=0, sticky=0, error stays 1.
REQ-029 data_valid=0 while data toggles between failing and passing patterns -> error, sticky and count unchanged.
REQ-030 Two boundary cases:
- Failing word with clear=1 on the same edge -> sticky=1, count=1.
- rst_n pulsed low between clock edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/parity_error_checker.sv
// Registered parity checker: flags each sampled word that violates the expected
// parity and keeps a sticky flag plus a saturating count of failed words.
module parity_error_checker #(
    parameter int DATA_W     = 6,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data,
    input  logic              data_valid,
    input  logic              clear,
    output logic              error,
    output logic              error_sticky,
    output logic [CNT_W-1:0]  error_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // data_valid is a one-way strobe with no ready: when 1 at a rising edge the
    // word on data is checked on that edge; when 0 the word is ignored.
    logic w_parity;
    logic w_fail_word;
    logic w_fail_check;
    logic w_cnt_max;

    logic             r_error;
    logic             r_error_sticky;
    logic [CNT_W-1:0] r_error_count;

    assign w_parity     = ^data;
    assign w_fail_word  = w_parity ^ (PARITY_ODD != 0);
    assign w_fail_check = data_valid & w_fail_word;
    assign w_cnt_max    = &r_error_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (data_valid) begin
            r_error <= w_fail_word;
        end
    end

    // A failing check outranks clear, so a same-edge clear leaves one recorded error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error_sticky <= 1'b0;
            r_error_count  <= '0;
        end else if (w_fail_check) begin
            r_error_sticky <= 1'b1;
            if (clear) begin
                r_error_count <= CNT_ONE;
            end else if (!w_cnt_max) begin
                r_error_count <= r_error_count + CNT_ONE;
            end
        end else if (clear) begin
            r_error_sticky <= 1'b0;
            r_error_count  <= '0;
        end
    end

    assign error        = r_error;
    assign error_sticky = r_error_sticky;
    assign error_count  = r_error_count;

endmodule

// File: tb/tb_parity_error_checker.sv
// Directed bench for parity_error_checker: an even-mode and an odd-mode instance
// share one stimulus stream; expected values are hand-computed.
module tb_parity_error_checker;

    logic       clk;
    logic       rst_n;
    logic [5:0] data;
    logic       data_valid;
    logic       clear;

    logic       ev_error, ev_sticky;
    logic [7:0] ev_count;
    logic       od_error, od_sticky;
    logic [7:0] od_count;

    int n_checks = 0;
    int n_errors = 0;

    parity_error_checker #(.DATA_W(6), .PARITY_ODD(0), .CNT_W(8)) u_even (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid), .clear(clear),
        .error(ev_error), .error_sticky(ev_sticky), .error_count(ev_count)
    );

    parity_error_checker #(.DATA_W(6), .PARITY_ODD(1), .CNT_W(8)) u_odd (
        .clk(clk), .rst_n(rst_n), .data(data), .data_valid(data_valid), .clear(clear),
        .error(od_error), .error_sticky(od_sticky), .error_count(od_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic [5:0] d, input logic v, input logic c);
        @(negedge clk);
        data       = d;
        data_valid = v;
        clear      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; data = '0; data_valid = 1'b0; clear = 1'b0;
        #1;
        check("reset_error",  {31'd0, ev_error},  0);
        check("reset_sticky", {31'd0, ev_sticky}, 0);
        check("reset_count",  {24'd0, ev_count},  0);
        check("reset_odd_error", {31'd0, od_error}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // all-zero word passes in even mode
        step(6'b000000, 1'b1, 1'b0);
        check("zero_error",  {31'd0, ev_error},  0);
        check("zero_sticky", {31'd0, ev_sticky}, 0);
        check("zero_count",  {24'd0, ev_count},  0);

        // sequence of three words
        step(6'b000100, 1'b1, 1'b0);
        check("seq1_error", {31'd0, ev_error}, 1);
        check("odd_seq1_error", {31'd0, od_error}, 0);
        step(6'b100100, 1'b1, 1'b0);
        check("seq2_error", {31'd0, ev_error}, 0);
        check("odd_seq2_error", {31'd0, od_error}, 1);
        step(6'b101000, 1'b1, 1'b0);
        check("seq3_error",  {31'd0, ev_error},  0);
        check("seq3_sticky", {31'd0, ev_sticky}, 1);
        check("seq3_count",  {24'd0, ev_count},  1);

        // idle cycles with toggling data must change nothing
        step(6'b000001, 1'b0, 1'b0);
        step(6'b000000, 1'b0, 1'b0);
        step(6'b000111, 1'b0, 1'b0);
        check("idle_error",  {31'd0, ev_error},  0);
        check("idle_sticky", {31'd0, ev_sticky}, 1);
        check("idle_count",  {24'd0, ev_count},  1);

        // plain clear
        step(6'b000000, 1'b0, 1'b1);
        check("clr_sticky", {31'd0, ev_sticky}, 0);
        check("clr_count",  {24'd0, ev_count},  0);

        // failing word and clear on the same edge
        step(6'b000001, 1'b1, 1'b0);
        step(6'b000001, 1'b1, 1'b0);
        check("pre_fc_count", {24'd0, ev_count}, 2);
        step(6'b000001, 1'b1, 1'b1);
        check("fc_sticky", {31'd0, ev_sticky}, 1);
        check("fc_count",  {24'd0, ev_count},  1);
        check("fc_error",  {31'd0, ev_error},  1);

        // saturation: 300 failing words from zero
        step(6'b000000, 1'b0, 1'b1);
        check("sat_start_count", {24'd0, ev_count}, 0);
        for (int i = 0; i < 300; i++) begin
            step(6'b000001, 1'b1, 1'b0);
            if (i == 253) check("sat_254_count", {24'd0, ev_count}, 254);
            if (i == 254) check("sat_255_count", {24'd0, ev_count}, 255);
        end
        check("sat_count",  {24'd0, ev_count},  255);
        check("sat_sticky", {31'd0, ev_sticky}, 1);
        check("sat_error",  {31'd0, ev_error},  1);
        step(6'b000000, 1'b0, 1'b1);
        check("sat_clr_count",  {24'd0, ev_count},  0);
        check("sat_clr_sticky", {31'd0, ev_sticky}, 0);
        check("sat_clr_error",  {31'd0, ev_error},  1);

        // passing word after clear leaves counters alone
        step(6'b000011, 1'b1, 1'b0);
        check("pass_error", {31'd0, ev_error}, 0);
        check("pass_count", {24'd0, ev_count}, 0);

        // saturate again, then pulse reset between edges
        for (int i = 0; i < 260; i++) step(6'b010000, 1'b1, 1'b0);
        check("resat_count", {24'd0, ev_count}, 255);
        @(negedge clk);
        data_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_error",  {31'd0, ev_error},  0);
        check("async_rst_sticky", {31'd0, ev_sticky}, 0);
        check("async_rst_count",  {24'd0, ev_count},  0);
        #1 rst_n = 1'b1;

        // first valid word after reset is checked normally
        step(6'b000100, 1'b1, 1'b0);
        check("post_rst_error",  {31'd0, ev_error},  1);
        check("post_rst_sticky", {31'd0, ev_sticky}, 1);
        check("post_rst_count",  {24'd0, ev_count},  1);
        check("post_rst_odd_error", {31'd0, od_error}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
